fb_stream_reader: RTL and testbench

- Read-side client for the team's synchronous block RAM, used by the etch-a-sketch framebuffer path.
- On a start pulse it sweeps addresses 0..L-1 and drives rd_addr.
- It absorbs the RAM's fixed read latency and presents words as a valid/ready stream with a last flag, so the display/SPI side can apply backpressure without losing words.

---
 rtl/fb_stream_reader_pkg.sv | 22 ++
 rtl/fb_stream_reader_skid_fifo.sv | 50 +++++
 rtl/fb_stream_reader.sv | 110 +++++++++++
 tb/tb_fb_stream_reader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fb_stream_reader_pkg.sv
// Shared types and constants for the framebuffer stream reader.
// FB_STREAM_READER_RAM_OREG_EN selects a RAM with an extra output register (latency 2).
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fb_state_e;

`ifdef FB_STREAM_READER_RAM_OREG_EN
    localparam int FB_RAM_LAT = 2;
`else
    localparam int FB_RAM_LAT = 1;
`endif

    // One slot per word that can be in the RAM pipeline, plus one for the word on display.
    function automatic int fb_fifo_depth();
        return FB_RAM_LAT + 1;
    endfunction

endpackage

// File: rtl/fb_stream_reader_skid_fifo.sv
// Small circular FIFO that absorbs RAM read latency under downstream backpressure.
// Simultaneous push and pop are allowed; the caller guarantees no overflow or underflow.
module fb_skid_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [W-1:0]               head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; clearing count makes any stale entry unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fb_stream_reader.sv
// Sweeps a synchronous block RAM over addresses 0..L-1 and streams the words with valid/ready/last.
// Build option FB_STREAM_READER_RAM_OREG_EN (via fb_pkg) selects RAM read latency 2 instead of 1.
module fb_stream_reader
    import fb_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(L)-1:0] rd_addr,
    input  logic [W-1:0]         rd_data,
    output logic [W-1:0]         m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);
    localparam int LAT = FB_RAM_LAT;
    localparam int D   = fb_fifo_depth();
    localparam int AW  = $clog2(L);
    localparam int IW  = $clog2(L + 1);
    localparam int CW  = $clog2(D + 1);

    localparam logic [IW-1:0] L_IDX     = IW'(L);
    localparam logic [IW-1:0] LAST_IDX  = IW'(L - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(L - 1);

    fb_state_e     state, next_state;
    logic [IW-1:0] issue_idx;
    logic [LAT-1:0] fly_vld;
    logic [LAT-1:0] fly_last;
    int            inflight;
    logic          issue;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic [W:0]    fifo_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (m_valid && m_ready && m_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        inflight = 0;
        for (int i = 0; i < LAT; i++) inflight += int'(fly_vld[i]);
    end

    // A pop in this cycle frees its slot for an issue on the same edge, so streaming has no bubbles.
    assign pop   = m_valid && m_ready;
    assign issue = (state == RUN) && (issue_idx < L_IDX)
                && (int'(fifo_count) + inflight < D + int'(pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_idx <= '0;
            rd_addr   <= '0;
            fly_vld   <= '0;
            fly_last  <= '0;
        end else begin
            fly_vld[0]  <= issue;
            fly_last[0] <= issue && (issue_idx == LAST_IDX);
            for (int i = 1; i < LAT; i++) begin
                fly_vld[i]  <= fly_vld[i-1];
                fly_last[i] <= fly_last[i-1];
            end
            if (state == IDLE && start) begin
                issue_idx <= '0;
                rd_addr   <= '0;
            end else if (issue) begin
                issue_idx <= issue_idx + IW'(1);
                rd_addr   <= (issue_idx >= LAST_IDX) ? LAST_ADDR : AW'(issue_idx + IW'(1));
            end
        end
    end

    fb_skid_fifo #(
        .W     (W + 1),
        .DEPTH (D)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fly_vld[LAT-1]),
        .push_data ({fly_last[LAT-1], rd_data}),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign m_valid = (fifo_count != '0);
    assign m_data  = m_valid ? fifo_head[W-1:0] : '0;
    assign m_last  = m_valid && fifo_head[W];

endmodule

// File: tb/tb_fb_stream_reader.sv
// Scoreboard bench for fb_stream_reader: stimulus queues expected words, a negedge monitor checks them.
module tb_fb_stream_reader;
    localparam int W = 8;
    localparam int L = 32;
`ifdef FB_STREAM_READER_RAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int D = LAT + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 busy, done;
    logic [$clog2(L)-1:0] rd_addr;
    logic [W-1:0]         rd_data;
    logic [W-1:0]         m_data;
    logic                 m_valid, m_last;
    logic                 m_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int busy_cycles = 0;

    logic [W:0] sb [$];

    fb_stream_reader #(.W(W), .L(L)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    // RAM model: ram[i] = 8'h10 + i, read latency LAT.
    logic [W-1:0] ram [L];
    logic [W-1:0] q1, q2;
    initial for (int i = 0; i < L; i++) ram[i] = 8'h10 + W'(i);
    always @(posedge clk) begin
        q1 <= ram[rd_addr];
        q2 <= q1;
    end
    assign rd_data = (LAT == 2) ? q2 : q1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_expected();
        for (int i = 0; i < L; i++) sb.push_back({(i == L - 1), 8'h10 + W'(i)});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_m_data"},  32'(m_data), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_last"},  32'(m_last), 0);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_done"},    32'(done), 0);
    endtask

    // Monitor: compares every transfer against the scoreboard and checks stall stability.
    logic       stall_prev = 1'b0;
    logic [W-1:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid), 1);
                check("stall_data", 32'(m_data), 32'(prev_data));
                check("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected no transfer", m_data);
                end else begin
                    logic [W:0] exp;
                    exp = sb.pop_front();
                    check("word_data", 32'(m_data), 32'(exp[W-1:0]));
                    check("word_last", 32'(m_last), 32'(exp[W]));
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (busy) busy_cycles++;
            if (done) done_count++;
        end
    end

    // mode 0: ready=1; 1: ready toggles 1,0,1,0; 2: ready=0 for the first 10 cycles; 3: restart pulse mid-sweep
    task automatic sweep(input int mode, output int lat);
        int cyc;
        int d0;
        bit seen;
        d0 = done_count;
        seen = 0;
        lat = -1;
        load_expected();
        @(posedge clk);
        #1;
        busy_cycles = 0;
        m_ready = (mode != 2);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (done_count == d0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            case (mode)
                1:       m_ready = (cyc % 2 == 0);
                2:       m_ready = (cyc >= 10);
                3:       start = (cyc == 7);
                default: m_ready = 1'b1;
            endcase
            if (mode == 2 && cyc == 9) begin
                check("stall_rd_addr", 32'(rd_addr), D);
                check("stall_first_valid", 32'(m_valid), 1);
                check("stall_first_data", 32'(m_data), 32'h10);
            end
            @(negedge clk);
            if (!seen && m_valid) begin
                seen = 1;
                lat = cyc;
            end
        end
        start = 1'b0;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("done_pulses", done_count - d0, 1);
        check("busy_after", 32'(busy), 0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int lat;
        #2;
        check_outputs_zero("reset");
        #20 rst = 1'b0;

        // Full-rate sweep: latency, busy length, order, last flag.
        sweep(0, lat);
        check("first_valid_latency", lat, LAT + 1);
        check("busy_cycles", busy_cycles, L + LAT + 1);

        sweep(1, lat);
        sweep(2, lat);
        sweep(3, lat);

        // Asynchronous reset mid-sweep with words in flight.
        load_expected();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_outputs_zero("midreset");
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        sweep(0, lat);
        check("post_reset_latency", lat, LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
